// File: rtl/outpass_pipe_config_mux.sv
// outpass_pipe_config_mux
// Output-pass BEL that routes NUM_CH switch-matrix signals to tile outputs.
// Each channel picks, from its own configuration field, one of four output
// modes (tapped delay line, rising-edge pulse, toggle, retriggerable pulse
// stretch) plus an optional output inversion. All sequential trackers run
// every enabled cycle regardless of mode, so a mode change selects a
// different, already-live view of the channel without disturbing state.
module outpass_pipe_config_mux #(
    parameter int NUM_CH       = 4,
    parameter int DEPTH        = 3,
    parameter int STRETCH_LEN  = 4,
    parameter int TAPW         = 2,
    parameter int CNTW         = 3,
    parameter int NoConfigBits = 20
) (
    input  logic                    UserCLK,
    input  logic                    RST,
    input  logic                    CE,
    input  logic [NUM_CH-1:0]       I,
    output logic [NUM_CH-1:0]       O,
    input  logic [NoConfigBits-1:0] ConfigBits
);

    // Width of one channel's configuration field: TAP, MODE[1:0], INV.
    localparam int FW = TAPW + 3;

    localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(STRETCH_LEN);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_ZERO = CNTW'(0);

    localparam logic [1:0] MODE_DELAY   = 2'b00;
    localparam logic [1:0] MODE_EDGE    = 2'b01;
    localparam logic [1:0] MODE_TOGGLE  = 2'b10;
    localparam logic [1:0] MODE_STRETCH = 2'b11;

    // Per-channel delay line; stage 1 is the first flop after the input.
    logic [NUM_CH-1:0][DEPTH:1]  s_q;
    logic [NUM_CH-1:0][DEPTH:1]  s_d;
    logic [NUM_CH-1:0]           edge_q;
    logic [NUM_CH-1:0]           edge_d;
    logic [NUM_CH-1:0]           tog_q;
    logic [NUM_CH-1:0]           tog_d;
    logic [NUM_CH-1:0][CNTW-1:0] cnt_q;
    logic [NUM_CH-1:0][CNTW-1:0] cnt_d;

    logic [NUM_CH-1:0]           rise_s;
    logic [NUM_CH-1:0]           raw_s;
    logic [NUM_CH-1:0][TAPW-1:0] tap_s;
    logic [NUM_CH-1:0][1:0]      mode_s;
    logic [NUM_CH-1:0]           inv_s;

    // Slice the flat configuration word into per-channel fields.
    always_comb begin
        tap_s  = {(NUM_CH*TAPW){1'b0}};
        mode_s = {(NUM_CH*2){1'b0}};
        inv_s  = {NUM_CH{1'b0}};
        for (int c = 0; c < NUM_CH; c++) begin
            tap_s[c]  = ConfigBits[c*FW +: TAPW];
            mode_s[c] = ConfigBits[c*FW+TAPW +: 2];
            inv_s[c]  = ConfigBits[c*FW+TAPW+2];
        end
    end

    // Next state of all trackers; with CE low everything (including the
    // stretch counter) holds. A rise reloads the counter even if it is
    // still running, which gives retriggering.
    always_comb begin
        s_d    = s_q;
        edge_d = edge_q;
        tog_d  = tog_q;
        cnt_d  = cnt_q;
        rise_s = {NUM_CH{1'b0}};
        for (int c = 0; c < NUM_CH; c++) begin
            rise_s[c] = I[c] & ~s_q[c][1];
        end
        if (CE) begin
            for (int c = 0; c < NUM_CH; c++) begin
                s_d[c][1] = I[c];
                for (int k = 2; k <= DEPTH; k++) begin
                    s_d[c][k] = s_q[c][k-1];
                end
                edge_d[c] = rise_s[c];
                tog_d[c]  = tog_q[c] ^ rise_s[c];
                if (rise_s[c]) begin
                    cnt_d[c] = CNT_LOAD;
                end else if (cnt_q[c] != CNT_ZERO) begin
                    cnt_d[c] = cnt_q[c] - CNT_ONE;
                end else begin
                    cnt_d[c] = CNT_ZERO;
                end
            end
        end else begin
            s_d    = s_q;
            edge_d = edge_q;
            tog_d  = tog_q;
            cnt_d  = cnt_q;
        end
    end

    // State registers with synchronous reset taking priority over CE.
    always_ff @(posedge UserCLK) begin
        if (RST) begin
            s_q    <= {(NUM_CH*DEPTH){1'b0}};
            edge_q <= {NUM_CH{1'b0}};
            tog_q  <= {NUM_CH{1'b0}};
            cnt_q  <= {(NUM_CH*CNTW){1'b0}};
        end else begin
            s_q    <= s_d;
            edge_q <= edge_d;
            tog_q  <= tog_d;
            cnt_q  <= cnt_d;
        end
    end

    // Output select: only DELAY with TAP=0 passes I through combinationally;
    // taps beyond DEPTH clamp to the last stage.
    always_comb begin
        raw_s = {NUM_CH{1'b0}};
        O     = {NUM_CH{1'b0}};
        for (int c = 0; c < NUM_CH; c++) begin
            case (mode_s[c])
                MODE_DELAY: begin
                    raw_s[c] = s_q[c][DEPTH];
                    for (int k = 1; k < DEPTH; k++) begin
                        raw_s[c] = (int'(tap_s[c]) == k) ? s_q[c][k] : raw_s[c];
                    end
                    raw_s[c] = (tap_s[c] == TAPW'(0)) ? I[c] : raw_s[c];
                end
                MODE_EDGE:    raw_s[c] = edge_q[c];
                MODE_TOGGLE:  raw_s[c] = tog_q[c];
                MODE_STRETCH: raw_s[c] = (cnt_q[c] != CNT_ZERO);
                default:      raw_s[c] = 1'b0;
            endcase
            O[c] = raw_s[c] ^ inv_s[c];
        end
    end

endmodule

// File: tb/tb_outpass_pipe_config_mux.sv
// Directed self-checking bench for outpass_pipe_config_mux. A second
// instance built with DEPTH=2 exercises tap clamping.
module tb_outpass_pipe_config_mux;

    logic        clk;
    logic        rst;
    logic        ce;
    logic [3:0]  din;
    logic [3:0]  dout;
    logic [3:0]  dout2;
    logic [19:0] cfg;
    logic [19:0] cfg2;

    int checks;
    int fails;

    outpass_pipe_config_mux #(
        .NUM_CH(4), .DEPTH(3), .STRETCH_LEN(4), .TAPW(2), .CNTW(3), .NoConfigBits(20)
    ) dut (
        .UserCLK(clk), .RST(rst), .CE(ce), .I(din), .O(dout), .ConfigBits(cfg)
    );

    outpass_pipe_config_mux #(
        .NUM_CH(4), .DEPTH(2), .STRETCH_LEN(4), .TAPW(2), .CNTW(3), .NoConfigBits(20)
    ) dut2 (
        .UserCLK(clk), .RST(rst), .CE(ce), .I(din), .O(dout2), .ConfigBits(cfg2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One channel field: {INV, MODE, TAP}.
    function automatic logic [4:0] fld(input logic [1:0] tap, input logic [1:0] mode,
                                       input logic inv);
        return {inv, mode, tap};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        cfg = {4{fld(2'd1, 2'b00, 1'b0)}};
        rst = 1'b1;
        din = 4'hF;
        tick();
        checks++;
        if (dout !== 4'b0000) begin
            fails++;
            $display("FAIL reset_inv0: O=%b expected %b", dout, 4'b0000);
        end
        din = 4'b0101;
        tick();
        checks++;
        if (dout !== 4'b0000) begin
            fails++;
            $display("FAIL reset_i_change: O=%b expected %b", dout, 4'b0000);
        end
        cfg = {4{fld(2'd1, 2'b00, 1'b1)}};
        #1;
        checks++;
        if (dout !== 4'b1111) begin
            fails++;
            $display("FAIL reset_inv1: O=%b expected %b", dout, 4'b1111);
        end
        din = 4'b0000;
        rst = 1'b0;
        tick();
        checks++;
        if (dout !== 4'b1111) begin
            fails++;
            $display("FAIL reset_release: O=%b expected %b", dout, 4'b1111);
        end
    endtask

    task automatic test_delay();
        logic [3:0] exp_t [5];
        exp_t = '{4'b1001, 4'b1000, 4'b1010, 4'b0100, 4'b1000};
        cfg = {fld(2'd3, 2'b00, 1'b1), fld(2'd3, 2'b00, 1'b0),
               fld(2'd2, 2'b00, 1'b0), fld(2'd0, 2'b00, 1'b0)};
        ce  = 1'b1;
        din = 4'h0;
        do_reset();
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            din = (i == 0) ? 4'hF : 4'h0;
            #1;
            checks++;
            if (dout !== exp_t[i]) begin
                fails++;
                $display("FAIL delay step %0d: O=%b expected %b", i, dout, exp_t[i]);
            end
        end
    endtask

    task automatic test_edge_toggle();
        logic       pat [10];
        logic [1:0] tt  [10];
        logic [3:0] exp_v;
        pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        // {toggle, edge} after the edge that samples pat[i]
        tt  = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00};
        cfg = {fld(2'd0, 2'b10, 1'b1), fld(2'd0, 2'b01, 1'b1),
               fld(2'd0, 2'b10, 1'b0), fld(2'd0, 2'b01, 1'b0)};
        din = 4'h0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            din = {4{pat[i]}};
            tick();
            exp_v = {~tt[i][1], ~tt[i][0], tt[i][1], tt[i][0]};
            checks++;
            if (dout !== exp_v) begin
                fails++;
                $display("FAIL edge_toggle step %0d: O=%b expected %b", i, dout, exp_v);
            end
        end
    endtask

    task automatic test_stretch();
        logic pat [19];
        logic hi  [19];
        logic [3:0] exp_v;
        pat = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
                1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        hi  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        cfg = {fld(2'd0, 2'b11, 1'b1), fld(2'd0, 2'b11, 1'b0),
               fld(2'd0, 2'b11, 1'b0), fld(2'd0, 2'b11, 1'b0)};
        din = 4'h0;
        do_reset();
        for (int i = 0; i < 19; i++) begin
            din = {4{pat[i]}};
            tick();
            exp_v = hi[i] ? 4'b0111 : 4'b1000;
            checks++;
            if (dout !== exp_v) begin
                fails++;
                $display("FAIL stretch step %0d: O=%b expected %b", i, dout, exp_v);
            end
        end
        // Reset in the middle of a stretch, then reset coinciding with a rise.
        din = 4'h0;
        tick();
        din = 4'hF;
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (dout !== 4'b1000) begin
            fails++;
            $display("FAIL stretch_mid_reset: O=%b expected %b", dout, 4'b1000);
        end
        din = 4'h0;
        tick();
        din = 4'hF;
        tick();
        checks++;
        if (dout !== 4'b1000) begin
            fails++;
            $display("FAIL stretch_reset_vs_rise: O=%b expected %b", dout, 4'b1000);
        end
        rst = 1'b0;
        din = 4'h0;
        tick();
        checks++;
        if (dout !== 4'b1000) begin
            fails++;
            $display("FAIL stretch_after_reset: O=%b expected %b", dout, 4'b1000);
        end
    endtask

    task automatic test_ce_hold();
        logic [3:0] exp_t [10];
        exp_t = '{4'b1100, 4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1110,
                  4'b1101, 4'b1100, 4'b1000};
        cfg = {fld(2'd0, 2'b10, 1'b0), fld(2'd0, 2'b11, 1'b0),
               fld(2'd2, 2'b00, 1'b0), fld(2'd3, 2'b00, 1'b0)};
        ce  = 1'b1;
        din = 4'h0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            ce  = (i >= 2 && i <= 6) ? 1'b0 : 1'b1;
            din = (i == 0 || (i >= 2 && i <= 6)) ? 4'hF : 4'h0;
            tick();
            checks++;
            if (dout !== exp_t[i]) begin
                fails++;
                $display("FAIL ce_hold step %0d: O=%b expected %b", i, dout, exp_t[i]);
            end
        end
        ce = 1'b1;
    endtask

    task automatic test_mode_switch();
        cfg = {4{fld(2'd1, 2'b10, 1'b0)}};
        din = 4'h0;
        do_reset();
        din = 4'hF;
        tick();
        din = 4'h0;
        tick();
        checks++;
        if (dout !== 4'b1111) begin
            fails++;
            $display("FAIL mode_toggle_set: O=%b expected %b", dout, 4'b1111);
        end
        cfg = {4{fld(2'd1, 2'b00, 1'b0)}};
        #1;
        checks++;
        if (dout !== 4'b0000) begin
            fails++;
            $display("FAIL mode_to_delay: O=%b expected %b", dout, 4'b0000);
        end
        cfg = {4{fld(2'd1, 2'b10, 1'b0)}};
        #1;
        checks++;
        if (dout !== 4'b1111) begin
            fails++;
            $display("FAIL mode_back_toggle: O=%b expected %b", dout, 4'b1111);
        end
        cfg = {4{fld(2'd0, 2'b00, 1'b0)}};
        din = 4'b1010;
        #1;
        checks++;
        if (dout !== 4'b1010) begin
            fails++;
            $display("FAIL mode_bypass: O=%b expected %b", dout, 4'b1010);
        end
        din = 4'h0;
        cfg = {4{fld(2'd0, 2'b10, 1'b0)}};
        #1;
        checks++;
        if (dout !== 4'b1111) begin
            fails++;
            $display("FAIL mode_tog_kept: O=%b expected %b", dout, 4'b1111);
        end
    endtask

    task automatic test_clamp();
        logic [3:0] exp_t [3];
        exp_t = '{4'b1100, 4'b0011, 4'b1000};
        cfg2 = {fld(2'd3, 2'b00, 1'b1), fld(2'd1, 2'b00, 1'b0),
                fld(2'd2, 2'b00, 1'b0), fld(2'd3, 2'b00, 1'b0)};
        din = 4'h0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            din = (i == 0) ? 4'hF : 4'h0;
            tick();
            checks++;
            if (dout2 !== exp_t[i]) begin
                fails++;
                $display("FAIL clamp step %0d: O=%b expected %b", i, dout2, exp_t[i]);
            end
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        rst    = 1'b1;
        ce     = 1'b1;
        din    = 4'h0;
        cfg    = 20'h00000;
        cfg2   = 20'h00000;
        tick();
        test_reset();
        test_delay();
        test_edge_toggle();
        test_stretch();
        test_ce_hold();
        test_mode_switch();
        test_clamp();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
